// File: rtl/rv32i_fetch_test_sequencer.sv
// rtl/rv32i_fetch_test_sequencer.sv - command sequencer driving RV32I fetch-stage image load, run and reset
module rv32i_fetch_test_sequencer #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 8,
    parameter int          CYCLE_W   = 9,
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_op_valid,
    input  logic [2:0]         i_op_code,
    input  logic [CYCLE_W-1:0] i_cycle_length,
    output logic               o_op_ready,
    output logic               o_tx_complete,
    input  logic               i_rx_continue,
    output logic               o_dut_rst,
    output logic               o_wr_en,
    output logic [31:0]        o_wr_addr,
    output logic [DATA_W-1:0]  o_wr_data,
    input  logic               i_wr_valid,
    input  logic               i_latch_en,
    output logic [CYCLE_W-1:0] o_latch_count,
    output logic               o_err,
    output logic               o_sim_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_RST   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    localparam logic [2:0] OP_LOAD     = 3'b000;
    localparam logic [2:0] OP_FETCH    = 3'b001;
    localparam logic [2:0] OP_END      = 3'b010;
    localparam logic [2:0] OP_RESET    = 3'b011;
    localparam logic [2:0] OP_LOAD_INV = 3'b100;

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic               inv_q, inv_d;
    logic [CYCLE_W-1:0] remain_q, remain_d;
    logic [CYCLE_W-1:0] count_q, count_d;
    logic               err_q, err_d;
    logic               dut_rst_q, dut_rst_d;
    logic               cont_q;
    logic [31:0]        k_addr;
    logic [DATA_W-1:0]  k_data;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        inv_d    = inv_q;
        remain_d = remain_q;
        count_d  = count_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_op_valid) begin
                    case (i_op_code)
                        OP_LOAD, OP_LOAD_INV: begin
                            state_d = S_LOAD;
                            k_d     = '0;
                            inv_d   = (i_op_code == OP_LOAD_INV);
                        end
                        OP_FETCH: begin
                            state_d  = S_FETCH;
                            remain_d = i_cycle_length;
                            count_d  = '0;
                        end
                        OP_END:   state_d = S_END;
                        OP_RESET: state_d = S_RST;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (i_wr_valid) begin
                    if (k_q == '1) state_d = S_DONE;
                    else           k_d = k_q + 1'b1;
                end
            end
            S_FETCH: begin
                if (i_latch_en && count_q != '1) count_d = count_q + 1'b1;
                // N=0 and N=1 both spend a single cycle here
                if (remain_q <= CYCLE_W'(1)) state_d = S_DONE;
                else                         remain_d = remain_q - 1'b1;
            end
            S_RST:  state_d = S_DONE;
            S_DONE: if (i_rx_continue && !cont_q) state_d = S_IDLE;
            S_END:  state_d = S_END;
            default: state_d = S_IDLE;
        endcase
        dut_rst_d = (state_d == S_LOAD) || (state_d == S_RST);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            inv_q     <= 1'b0;
            remain_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            dut_rst_q <= 1'b1;
            cont_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            inv_q     <= inv_d;
            remain_q  <= remain_d;
            count_q   <= count_d;
            err_q     <= err_d;
            dut_rst_q <= dut_rst_d;
            cont_q    <= i_rx_continue;
        end
    end

    always_comb begin
        k_addr                = '0;
        k_addr[ADDR_W-1:0]    = k_q;
        k_data                = '0;
        k_data[ADDR_W-1:0]    = k_q;
    end

    assign o_op_ready    = (state_q == S_IDLE);
    assign o_tx_complete = (state_q == S_DONE);
    assign o_wr_en       = (state_q == S_LOAD);
    assign o_wr_addr     = o_wr_en ? (LOAD_BASE + k_addr) : 32'h0;
    assign o_wr_data     = o_wr_en ? (inv_q ? ~k_data : k_data) : '0;
    assign o_dut_rst     = dut_rst_q;
    assign o_latch_count = count_q;
    assign o_err         = err_q;
    assign o_sim_done    = (state_q == S_END);

endmodule

// File: tb/tb_rv32i_fetch_test_sequencer.sv
// tb/tb_rv32i_fetch_test_sequencer.sv - randomized self-checking bench for rv32i_fetch_test_sequencer
module tb_rv32i_fetch_test_sequencer;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [8:0]  cycle_length;
    logic        op_ready;
    logic        tx_complete;
    logic        rx_continue;
    logic        dut_rst;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        latch_en;
    logic [8:0]  latch_count;
    logic        err;
    logic        sim_done;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_err  = 1'b0;

    always #5 clk = ~clk;

    rv32i_fetch_test_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .i_op_code(op_code),
        .i_cycle_length(cycle_length), .o_op_ready(op_ready), .o_tx_complete(tx_complete),
        .i_rx_continue(rx_continue), .o_dut_rst(dut_rst), .o_wr_en(wr_en),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_valid(wr_valid),
        .i_latch_en(latch_en), .o_latch_count(latch_count), .o_err(err), .o_sim_done(sim_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input int len);
        chk("ready_before_cmd", 32'(op_ready), 1);
        op_valid     = 1'b1;
        op_code      = op;
        cycle_length = 9'(len);
        step();
        op_valid     = 1'b0;
        op_code      = 3'($urandom);
        cycle_length = 9'($urandom);
    endtask

    task automatic release_done(input string tag);
        chk({tag, "_txc"}, 32'(tx_complete), 1);
        chk({tag, "_busy"}, 32'(op_ready), 0);
        rx_continue = 1'b1;
        step();
        chk({tag, "_idle"}, 32'(op_ready), 1);
        chk({tag, "_txc_off"}, 32'(tx_complete), 0);
        rx_continue = 1'b0;
    endtask

    // mode 0: ack every cycle, 1: ack every 3rd cycle, 2: random acks; abort_at >= 0 pulses reset at that k
    task automatic run_load(input bit inv, input int mode, input int abort_at);
        int k = 0, cyc = 0, bad_addr = 0, bad_data = 0, bad_rst = 0;
        logic [31:0] expd, first_d = 'x, last_d = 'x;
        logic ack;
        bit aborted = 0;
        issue(inv ? 3'b100 : 3'b000, 0);
        chk("load_wr_en_on", 32'(wr_en), 1);
        while (wr_en && cyc < 5000 && !aborted) begin
            expd = inv ? ~32'(k) : 32'(k);
            if (wr_addr !== BASE + 32'(k)) bad_addr++;
            if (wr_data !== expd) bad_data++;
            if (!dut_rst) bad_rst++;
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_wr_en", 32'(wr_en), 0);
                chk("abort_dut_rst", 32'(dut_rst), 1);
                step();
                rst = 1'b0;
                wr_valid = 1'b0;
                exp_err = 1'b0;
                chk("abort_rst_hold", 32'(dut_rst), 1);
                step();
                chk("abort_ready", 32'(op_ready), 1);
                chk("abort_dut_rst_low", 32'(dut_rst), 0);
                aborted = 1;
            end else begin
                ack = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 3) == 2) : 1'($urandom_range(0, 1));
                wr_valid = ack;
                if (ack && k == 0) first_d = wr_data;
                if (ack && k == DEPTH - 1) last_d = wr_data;
                step();
                if (ack) k++;
                cyc++;
            end
        end
        wr_valid = 1'b0;
        chk("load_bad_addr", 32'(bad_addr), 0);
        chk("load_bad_data", 32'(bad_data), 0);
        chk("load_bad_rst", 32'(bad_rst), 0);
        if (!aborted) begin
            chk("load_writes", 32'(k), DEPTH);
            chk("load_data0", first_d, inv ? 32'hFFFF_FFFF : 32'h0);
            chk("load_data255", last_d, inv ? 32'hFFFF_FF00 : 32'hFF);
            if (mode == 0) chk("load_cycles_tied", 32'(cyc), DEPTH);
            if (mode == 1) chk("load_cycles_3rd", 32'(cyc), 3 * DEPTH);
            chk("load_wr_en_off", 32'(wr_en), 0);
            chk("load_dut_rst_off", 32'(dut_rst), 0);
            release_done("load");
        end
    endtask

    task automatic run_fetch(input int n, input bit use_pat, input logic [31:0] pat);
        int cycles = (n == 0) ? 1 : n;
        int sum = 0, early = 0;
        logic le;
        issue(3'b001, n);
        chk("fetch_count_clr", 32'(latch_count), 0);
        for (int c = 0; c < cycles; c++) begin
            if (tx_complete) early++;
            le = use_pat ? pat[c % 32] : 1'($urandom_range(0, 1));
            latch_en = le;
            if (le) sum++;
            step();
        end
        latch_en = 1'b0;
        chk("fetch_early_done", 32'(early), 0);
        chk("fetch_done", 32'(tx_complete), 1);
        chk("fetch_count", 32'(latch_count), (sum > 511) ? 511 : sum);
        latch_en = 1'b1;
        step();
        step();
        latch_en = 1'b0;
        chk("fetch_count_hold", 32'(latch_count), (sum > 511) ? 511 : sum);
        release_done("fetch");
    endtask

    task automatic run_reset_cmd();
        issue(3'b011, 0);
        chk("rstcmd_dut_rst", 32'(dut_rst), 1);
        chk("rstcmd_txc0", 32'(tx_complete), 0);
        step();
        chk("rstcmd_dut_rst_off", 32'(dut_rst), 0);
        release_done("rstcmd");
    endtask

    task automatic run_illegal(input logic [2:0] op);
        issue(op, 0);
        exp_err = 1'b1;
        chk("illegal_err", 32'(err), 1);
        release_done("illegal");
    endtask

    initial begin
        int cnt;
        rst = 1'b1; op_valid = 1'b0; op_code = 3'b0; cycle_length = '0;
        rx_continue = 1'b0; wr_valid = 1'b0; latch_en = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(op_ready), 1);
        chk("rst_dut_rst", 32'(dut_rst), 1);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_txc", 32'(tx_complete), 0);
        chk("rst_count", 32'(latch_count), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sim_done", 32'(sim_done), 0);
        rst = 1'b0;
        #1;
        chk("rst_release_hold", 32'(dut_rst), 1);
        step();
        chk("rst_release_drop", 32'(dut_rst), 0);

        run_load(1'b0, 0, -1);
        run_load(1'b1, 1, -1);
        run_fetch(5, 1'b1, 32'b10101);
        run_fetch(0, 1'b0, 32'h0);
        run_fetch(1, 1'b1, 32'h1);

        // continue held high across DONE entry must not release
        issue(3'b011, 0);
        rx_continue = 1'b1;
        step();
        repeat (3) step();
        chk("hold_txc", 32'(tx_complete), 1);
        rx_continue = 1'b0;
        step();
        chk("hold_txc_low", 32'(tx_complete), 1);
        rx_continue = 1'b1;
        step();
        chk("hold_release", 32'(op_ready), 1);
        step();
        chk("hold_one_advance", 32'(op_ready), 1);
        issue(3'b011, 0);
        repeat (4) step();
        chk("hold_again_txc", 32'(tx_complete), 1);
        rx_continue = 1'b0;
        step();
        release_done("hold");

        run_load(1'b0, 0, 100);
        run_illegal(3'b111);
        chk("err_sticky", 32'(err), 1);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 4))
                0: run_load(1'b0, 2, -1);
                1: run_load(1'b1, 2, -1);
                2: run_fetch(int'($urandom_range(0, 40)), 1'b0, 32'h0);
                3: run_reset_cmd();
                default: run_illegal(3'(5 + $urandom_range(0, 2)));
            endcase
            chk("rand_err", 32'(err), 32'(exp_err));
        end

        issue(3'b010, 0);
        chk("end_sim_done", 32'(sim_done), 1);
        chk("end_ready", 32'(op_ready), 0);
        chk("end_txc", 32'(tx_complete), 0);
        cnt = 0;
        op_valid = 1'b1;
        op_code = 3'b000;
        rx_continue = 1'b1;
        repeat (10) begin
            step();
            if (wr_en) cnt++;
        end
        op_valid = 1'b0;
        rx_continue = 1'b0;
        chk("end_ignores_load", 32'(cnt), 0);
        chk("end_absorbing", 32'(sim_done), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("end_rst_sim_done", 32'(sim_done), 0);
        chk("end_rst_err", 32'(err), 0);
        chk("end_rst_ready", 32'(op_ready), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
